// File: rtl/uart_pkg.sv
//==============================================================================
// Module  : uart_pkg
// Brief   : Shared UART constants, receive state encoding and parity helper.
// Revision: 1.0
//==============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_PT  = 7;

  // Even parity expects an even total count of ones; odd expects an odd count.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic par_bit,
                                      input logic odd);
    return (^data ^ par_bit) != odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core_if.sv
//==============================================================================
// Module  : uart_rx_core_if
// Brief   : Line, configuration and status bundle between rx core and its bus.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface uart_rx_core_if import uart_pkg::*; ();

  logic                 rx_in;
  logic                 Rx_en;
  logic                 Two_stop;
  logic                 Odd_parity;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 rx_busy;

  modport master (
    output rx_in, Rx_en, Two_stop, Odd_parity, rx_ack,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );

  modport slave (
    input  rx_in, Rx_en, Two_stop, Odd_parity, rx_ack,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
//==============================================================================
// Module  : uart_rx_baud_gen
// Brief   : Free-running BAUD_DIV divider emitting a one-cycle oversample tick.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_rx_baud_gen #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          w_wrap;

  assign w_wrap = (cnt_q == CW'(BAUD_DIV - 1));
  assign tick_o = en_i & w_wrap;

  always_ff @(posedge clk) begin
    if (reset || !en_i) begin
      cnt_q <= '0;
    end else if (w_wrap) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
//==============================================================================
// Module  : uart_rx_core
// Brief   : 16x oversampling UART receiver, 8 data bits + parity + 1/2 stop.
// Revision: 1.0
//==============================================================================
`default_nettype none

module uart_rx_core import uart_pkg::*; #(
  parameter int BAUD_DIV = 27,
  parameter int SYNC_FF  = 2
) (
  input logic           clk,
  input logic           reset,
  uart_rx_core_if.slave bus
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_START  = START;
  localparam logic [2:0] S_DATA   = DATA;
  localparam logic [2:0] S_PARITY = PARITY;
  localparam logic [2:0] S_STOP1  = STOP1;
  localparam logic [2:0] S_STOP2  = STOP2;

  logic [SYNC_FF-1:0]   sync_q;
  logic                 line_q;
  logic [2:0]           state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 two_stop_q, two_stop_d, odd_q, odd_d;
  logic                 perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d, perr_q, perr_d;
  logic                 ferr_q, ferr_d, ovr_q, ovr_d;
  logic                 w_tick, w_line, w_fall, w_sample;

  uart_rx_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .en_i  (bus.Rx_en),
    .tick_o(w_tick)
  );

  assign w_line   = sync_q[SYNC_FF-1];
  assign w_fall   = line_q & ~w_line;
  assign w_sample = w_tick && (os_cnt_q == 4'(SAMPLE_PT));

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
    odd_d      = odd_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    done_d     = 1'b0;
    data_d     = data_q;
    valid_d    = bus.rx_ack ? 1'b0 : valid_q;
    perr_d     = bus.rx_ack ? 1'b0 : perr_q;
    ferr_d     = bus.rx_ack ? 1'b0 : ferr_q;
    ovr_d      = bus.rx_ack ? 1'b0 : ovr_q;

    // An ack in the completion cycle frees the buffer for the new byte.
    if (done_q) begin
      if (valid_q && !bus.rx_ack) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = perr_d | perr_acc_q;
        ferr_d  = ferr_d | ferr_acc_q;
      end
    end

    if (!bus.Rx_en) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (w_fall) begin
        state_d    = S_START;
        os_cnt_d   = '0;
        bit_cnt_d  = '0;
        two_stop_d = bus.Two_stop;
        odd_d      = bus.Odd_parity;
        perr_acc_d = 1'b0;
        ferr_acc_d = 1'b0;
      end
    end else begin
      if (w_tick) os_cnt_d = os_cnt_q + 1'b1;
      if (w_sample) begin
        case (state_q)
          S_START:  state_d = w_line ? S_IDLE : S_DATA;
          S_DATA: begin
            shift_d   = {w_line, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
          end
          S_PARITY: begin
            perr_acc_d = parity_bad(shift_q, w_line, odd_q);
            state_d    = S_STOP1;
          end
          S_STOP1: begin
            if (!w_line) ferr_acc_d = 1'b1;
            if (two_stop_q) begin
              state_d = S_STOP2;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
          S_STOP2: begin
            if (!w_line) ferr_acc_d = 1'b1;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '1;
      line_q     <= 1'b1;
      state_q    <= S_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      odd_q      <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_FF-2:0], bus.rx_in};
      line_q     <= w_line;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      odd_q      <= odd_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;
  assign bus.rx_busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire
